// File: rtl/bist_pattern_misr.sv
// BIST engine for the c880 combinational block: a 60-bit LFSR drives pat_o and
// a 26-bit MISR compacts resp_i for NPAT patterns per run.
// Optional macro BIST_GOLDEN_CMP_EN: registers pass_o = (final signature == GOLDEN)
// on DONE entry. Without it pass_o is tied low and GOLDEN is unused.
module bist_pattern_misr #(
    parameter int unsigned NPAT   = 1024,
    parameter logic [59:0] SEED   = 60'h1,
    parameter logic [25:0] GOLDEN = 26'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [59:0] pat_o,
    input  logic [25:0] resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [25:0] sig_o,
    output logic        pass_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [15:0] LastCnt = 16'(NPAT - 1);

    state_e      r_state, w_state_next;
    logic [59:0] r_lfsr, w_lfsr_next;
    logic [25:0] r_misr, w_misr_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic        w_last;
    logic        w_fb;

    assign w_last = (r_cnt == LastCnt);
    assign w_fb   = r_misr[25] ^ r_misr[5] ^ r_misr[1] ^ r_misr[0];

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_lfsr  <= '0;
            r_misr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_misr  <= w_misr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and datapath update; abort wins and freezes the datapath.
    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_misr_next  = r_misr;
        w_cnt_next   = r_cnt;
        if (abort_i) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start_i) w_state_next = StLoad;
                end
                StLoad: begin
                    w_lfsr_next  = SEED;
                    w_misr_next  = '0;
                    w_cnt_next   = '0;
                    w_state_next = StRun;
                end
                StRun: begin
                    // Response sampled here belongs to the pattern held this cycle.
                    w_misr_next = {r_misr[24:0], w_fb} ^ resp_i;
                    w_lfsr_next = {r_lfsr[58:0], r_lfsr[59] ^ r_lfsr[58]};
                    if (w_last) begin
                        w_state_next = StDone;
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    assign pat_o  = r_lfsr;
    assign sig_o  = r_misr;
    assign busy_o = (r_state == StLoad) || (r_state == StRun);
    assign done_o = (r_state == StDone);

`ifdef BIST_GOLDEN_CMP_EN
    logic r_pass;

    // Capture the compare on DONE entry, hold through DONE, clear on leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else begin
            r_pass <= (w_state_next == StDone) &&
                      ((r_state == StRun) ? (w_misr_next == GOLDEN) : r_pass);
        end
    end

    assign pass_o = r_pass;
`else
    logic w_unused_golden;

    assign w_unused_golden = ^GOLDEN;
    assign pass_o          = 1'b0;
`endif

endmodule

// File: doc/bist_pattern_misr.md
BIST_PATTERN_MISR -- requirements
Module: bist_pattern_misr

Interface
REQ-001 Parameter NPAT, default 1024, range 1..65535: number of patterns applied per run.
REQ-002 Parameter SEED, default 60'h1, must be nonzero: LFSR load value at run start.
REQ-003 Parameter GOLDEN, default 26'h0: expected final signature. Used only with BIST_GOLDEN_CMP_EN.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle run request.
REQ-007 abort_i  input  1  cancel run, return to IDLE.
REQ-008 pat_o  output  60  stimulus to the c880 input vector, N1 (bit0) ... N268 (bit59), in port-list order.
REQ-009 resp_i  input  26  c880 response vector, N388 (bit0) ... N880 (bit25), in port-list order.
REQ-010 busy_o  output  1  high in LOAD and RUN.
REQ-011 done_o  output  1  high in DONE.
REQ-012 sig_o  output  26  current MISR contents.
REQ-013 pass_o  output  1  signature-match flag.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DONE. Encoding is free.
REQ-015 IDLE, start_i=1 -> LOAD; DONE, start_i=1 -> LOAD; start_i in LOAD/RUN SHALL be ignored.
REQ-016 LOAD (exactly one cycle): lfsr<=SEED, misr<=0, cnt<=0; next state RUN.
REQ-017 RUN, each cycle: misr absorbs resp_i; lfsr advances; cnt<=cnt+1.
REQ-018 RUN with cnt==NPAT-1: the last absorb occurs and the next state is DONE.
REQ-019 DUT is combinational: the resp_i sampled at a RUN edge SHALL correspond to the pat_o held during that cycle.
REQ-020 LFSR step: lfsr <= {lfsr[58:0], lfsr[59]^lfsr[58]}.
REQ-021 pat_o = lfsr register, direct with no extra stage.
REQ-022 MISR step: fb = misr[25]^misr[5]^misr[1]^misr[0]; misr <= {misr[24:0], fb} ^ resp_i.
REQ-023 cnt is 16 bits, never wraps; it stops at NPAT-1.
REQ-024 Exactly NPAT responses SHALL be absorbed per run, and sig_o SHALL be frozen in IDLE and DONE.
REQ-025 abort_i has priority over start_i in every state: next state IDLE; lfsr, misr and cnt hold their values.
REQ-026 Latency: DONE is entered NPAT+1 cycles after the edge that samples start_i.
REQ-027 done_o stays high until start_i, abort_i or rst.

Reset
REQ-028 On rst: state=IDLE, lfsr=0, misr=0, cnt=0, pat_o=0, sig_o=0, busy_o=0, done_o=0, pass_o=0, applied immediately, independent of clk.
REQ-029 rst asserted mid-RUN SHALL discard the run; no partial done_o pulse.

Configuration
REQ-030 Macro BIST_GOLDEN_CMP_EN, when defined: pass_o = done_o & (misr==GOLDEN), registered with the DONE entry.
REQ-031 Without BIST_GOLDEN_CMP_EN: pass_o tied 0, GOLDEN unused, no comparator logic.

Verification
REQ-032 Reset mid-RUN -> all outputs 0 asynchronously; a following start_i gives a full, correct run.
REQ-033 SEED=1, start_i pulse -> LOAD; pat_o=60'h1 in the first RUN cycle, 60'h2 in the second, 60'h4 in the third.
REQ-034 NPAT=2, resp_i held at 26'h1 -> sig_o=26'h2, done_o=1 exactly 3 cycles after start_i sampled.
REQ-035 NPAT=1, resp_i=26'h1, GOLDEN=26'h1, macro defined -> pass_o=1; with GOLDEN=26'h2 -> pass_o=0.
REQ-036 abort_i in RUN cycle 5 -> IDLE next cycle, busy_o=0, done_o never asserted; start_i re-pulsed during RUN -> ignored, cycle count unchanged.
REQ-037 Full NPAT=1024 run against the c880 netlist -> sig_o matches the reference-model signature, and the run is bit-exact across two repeated runs.
